// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: per-stage register IDs, write enables and
// memory handshake going in; stall/flush/forward controls and debug
// counters coming back out to the pipeline.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);

  // Decode-stage sources
  logic [4:0]       RS1_D;
  logic [4:0]       RS2_D;
  // Execute-stage sources/destination
  logic [4:0]       RS1_E;
  logic [4:0]       RS2_E;
  logic [4:0]       RD_E;
  logic             ResultSrcE;
  logic             PCSrcE;
  // Memory and writeback destinations
  logic [4:0]       RD_M;
  logic             RegWriteM;
  logic [4:0]       RD_W;
  logic             RegWriteW;
  // Data-memory handshake
  logic             MemReqM;
  logic             MemReadyM;
  // Counter control
  logic             CntClr;

  // Pipeline controls
  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             StallM;
  logic             FlushD;
  logic             FlushE;
  logic             FlushW;
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic             MemErr;
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] FlushCount;

  // Pipeline side: drives the stage information, consumes the controls
  modport master (
    output RS1_D, RS2_D, RS1_E, RS2_E, RD_E, ResultSrcE, PCSrcE,
           RD_M, RegWriteM, RD_W, RegWriteW, MemReqM, MemReadyM, CntClr,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, MemErr, StallCount, FlushCount
  );

  // Controller side
  modport slave (
    input  RS1_D, RS2_D, RS1_E, RS2_E, RD_E, ResultSrcE, PCSrcE,
           RD_M, RegWriteM, RD_W, RegWriteW, MemReqM, MemReadyM, CntClr,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, MemErr, StallCount, FlushCount
  );

endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall controller for the five-stage pipeline: operand
// forwarding, load-use stalls, branch flushes, data-memory wait stalls
// with a timeout error state, and saturating stall/flush counters.
// MEM_TIMEOUT is legal in 2..255 (the wait counter is 8 bits).
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  state_t           state_q, state_d;
  logic [7:0]       wcnt_q, wcnt_d;
  logic [7:0]       wcnt_inc;
  logic             mem_miss;
  logic             lw_stall;
  logic             mem_wait;

  logic             stall_f, stall_d, stall_e, stall_m;
  logic             flush_d, flush_e, flush_w;
  logic             mem_err;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Newest producer wins; r0 is hard-wired zero so it is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       we_m,
    input logic [4:0] rd_w,
    input logic       we_w
  );
    if (we_m && (rd_m != 5'd0) && (rd_m == rs)) return FWD_MEM;
    if (we_w && (rd_w != 5'd0) && (rd_w == rs)) return FWD_WB;
    return FWD_RF;
  endfunction

  assign mem_miss = hz.MemReqM && !hz.MemReadyM;
  assign lw_stall = hz.ResultSrcE && (hz.RD_E != 5'd0) &&
                    ((hz.RD_E == hz.RS1_D) || (hz.RD_E == hz.RS2_D));
  assign wcnt_inc = wcnt_q + 8'd1;

  // A wait stall persists while MEM_WAIT sees no ready, and starts the
  // very cycle RUN sees a miss, so outputs have zero latency.
  assign mem_wait = ((state_q == MEM_WAIT) && !hz.MemReadyM) ||
                    ((state_q == RUN) && mem_miss);

  // Forwarding selects; active in every state, forced to 00 during reset
  always_comb begin
    fwd_a = fwd_sel(hz.RS1_E, hz.RD_M, hz.RegWriteM, hz.RD_W, hz.RegWriteW);
    fwd_b = fwd_sel(hz.RS2_E, hz.RD_M, hz.RegWriteM, hz.RD_W, hz.RegWriteW);
    if (rst) begin
      fwd_a = FWD_RF;
      fwd_b = FWD_RF;
    end
  end

  // State and wait-counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      wcnt_q  <= 8'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Next-state logic and prioritised stall/flush outputs
  always_comb begin
    // NOTE: every output of this block is defaulted first, so no path
    // through the case/if tree can leave one unassigned and infer a latch.
    state_d = state_q;
    wcnt_d  = wcnt_q;
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    mem_err = 1'b0;

    unique case (state_q)
      RUN: begin
        if (mem_miss) begin
          state_d = MEM_WAIT;
          wcnt_d  = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (hz.MemReadyM) begin
          state_d = RUN;
          wcnt_d  = 8'd0;
        end else if (wcnt_inc == TIMEOUT) begin
          state_d = ERROR;
        end else begin
          wcnt_d = wcnt_inc;
        end
      end
      ERROR: state_d = ERROR;
      default: begin
        state_d = RUN;
        wcnt_d  = 8'd0;
      end
    endcase

    // Priority: ERROR > memory wait > branch > load-use. During a wait the
    // branch stays frozen in execute and flushes once the wait ends.
    if (state_q == ERROR) begin
      {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
      flush_w = 1'b1;
      mem_err = 1'b1;
    end else if (mem_wait) begin
      {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
      flush_w = 1'b1;
    end else if (hz.PCSrcE) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (lw_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end

    if (rst) begin
      {stall_f, stall_d, stall_e, stall_m} = 4'b0000;
      {flush_d, flush_e, flush_w}          = 3'b000;
    end
  end

  // Saturating performance counters; clear beats increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (hz.CntClr) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_f && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_e && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign hz.StallF     = stall_f;
  assign hz.StallD     = stall_d;
  assign hz.StallE     = stall_e;
  assign hz.StallM     = stall_m;
  assign hz.FlushD     = flush_d;
  assign hz.FlushE     = flush_e;
  assign hz.FlushW     = flush_w;
  assign hz.ForwardAE  = fwd_a;
  assign hz.ForwardBE  = fwd_b;
  assign hz.MemErr     = mem_err;
  assign hz.StallCount = stall_cnt_q;
  assign hz.FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: forwarding priority, load-use,
// branch priority, memory wait, timeout/error recovery and counter
// saturation/clear. Runs with MEM_TIMEOUT = 4 and CNT_W = 4.
module tb_pipeline_hazard_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  pipeline_hazard_ctrl_if #(.CNT_W(4)) hz ();

  pipeline_hazard_ctrl #(
    .MEM_TIMEOUT(4),
    .CNT_W      (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {StallF, StallD, StallE, StallM}
  function automatic logic [31:0] stalls();
    return {28'd0, hz.StallF, hz.StallD, hz.StallE, hz.StallM};
  endfunction

  // {FlushD, FlushE, FlushW}
  function automatic logic [31:0] flushes();
    return {29'd0, hz.FlushD, hz.FlushE, hz.FlushW};
  endfunction

  // {ForwardAE, ForwardBE}
  function automatic logic [31:0] fwds();
    return {28'd0, hz.ForwardAE, hz.ForwardBE};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    hz.RS1_D      = 5'd0;
    hz.RS2_D      = 5'd0;
    hz.RS1_E      = 5'd0;
    hz.RS2_E      = 5'd0;
    hz.RD_E       = 5'd0;
    hz.ResultSrcE = 1'b0;
    hz.PCSrcE     = 1'b0;
    hz.RD_M       = 5'd0;
    hz.RegWriteM  = 1'b0;
    hz.RD_W       = 5'd0;
    hz.RegWriteW  = 1'b0;
    hz.MemReqM    = 1'b0;
    hz.MemReadyM  = 1'b0;
    hz.CntClr     = 1'b0;
  endtask

  task automatic set_load_use();
    hz.ResultSrcE = 1'b1;
    hz.RD_E       = 5'd5;
    hz.RS2_D      = 5'd5;
  endtask

  task automatic clear_counters();
    hz.CntClr = 1'b1;
    tick();
    hz.CntClr = 1'b0;
  endtask

  // Safety net against a stuck simulation
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    clear_inputs();

    // Reset: provoke every hazard source, all controls must stay low
    hz.RS1_E      = 5'd3;
    hz.RD_M       = 5'd3;
    hz.RegWriteM  = 1'b1;
    hz.PCSrcE     = 1'b1;
    set_load_use();
    hz.MemReqM    = 1'b1;
    #12;
    check("rst_stalls",  stalls(),  32'h0);
    check("rst_flushes", flushes(), 32'h0);
    check("rst_fwd",     fwds(),    32'h0);
    check("rst_memerr",  32'(hz.MemErr),     32'd0);
    check("rst_stallcnt", 32'(hz.StallCount), 32'd0);
    check("rst_flushcnt", 32'(hz.FlushCount), 32'd0);
    clear_inputs();
    rst = 1'b0;
    tick();

    // Forwarding priority: memory stage beats writeback
    hz.RS1_E     = 5'd3;
    hz.RS2_E     = 5'd3;
    hz.RD_M      = 5'd3;
    hz.RegWriteM = 1'b1;
    hz.RD_W      = 5'd3;
    hz.RegWriteW = 1'b1;
    #1 check("fwd_mem_pri", fwds(), 32'b1010);
    hz.RegWriteM = 1'b0;
    #1 check("fwd_wb", fwds(), 32'b0101);
    hz.RegWriteM = 1'b1;
    hz.RS1_E     = 5'd0;
    hz.RS2_E     = 5'd0;
    hz.RD_M      = 5'd0;
    hz.RD_W      = 5'd0;
    #1 check("fwd_r0", fwds(), 32'b0000);
    hz.RS1_E = 5'd4;
    hz.RD_M  = 5'd4;
    hz.RS2_E = 5'd9;
    hz.RD_W  = 5'd9;
    #1 check("fwd_mixed", fwds(), 32'b1001);
    clear_inputs();

    // Load-use: one stall cycle, counters follow one cycle later
    clear_counters();
    set_load_use();
    #1 check("lw_stalls",  stalls(),  32'b1100);
    check("lw_flushes", flushes(), 32'b010);
    tick();
    clear_inputs();
    #1 check("lw_done", stalls(), 32'b0000);
    check("lw_stallcnt", 32'(hz.StallCount), 32'd1);
    check("lw_flushcnt", 32'(hz.FlushCount), 32'd1);

    // Load with rd = r0 never stalls
    hz.ResultSrcE = 1'b1;
    hz.RD_E       = 5'd0;
    hz.RS1_D      = 5'd0;
    #1 check("lw_r0", stalls(), 32'b0000);
    clear_inputs();

    // Branch beats load-use
    set_load_use();
    hz.PCSrcE = 1'b1;
    #1 check("br_stalls",  stalls(),  32'b0000);
    check("br_flushes", flushes(), 32'b110);
    tick();
    clear_inputs();

    // Memory wait: 3 not-ready cycles, branch held throughout
    hz.MemReqM   = 1'b1;
    hz.MemReadyM = 1'b0;
    hz.PCSrcE    = 1'b1;
    hz.RS1_E     = 5'd6;
    hz.RD_M      = 5'd6;
    hz.RegWriteM = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("mw_stalls_%0d", i),  stalls(),  32'b1111);
      check($sformatf("mw_flushes_%0d", i), flushes(), 32'b001);
      if (i == 1) check("mw_fwd", fwds(), 32'b1000);
      tick();
    end
    hz.MemReadyM = 1'b1;
    #1 check("mw_ready_stalls",  stalls(),  32'b0000);
    check("mw_ready_flushes", flushes(), 32'b110);
    tick();
    clear_inputs();
    #1 check("mw_back_run", stalls(), 32'b0000);

    // Access ready in its first cycle: no stall
    hz.MemReqM   = 1'b1;
    hz.MemReadyM = 1'b1;
    #1 check("mw_first_ready", stalls(), 32'b0000);
    tick();
    clear_inputs();

    // Timeout: MEM_TIMEOUT = 4, never ready
    hz.MemReqM   = 1'b1;
    hz.MemReadyM = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1 check($sformatf("to_wait_err_%0d", i), 32'(hz.MemErr), 32'd0);
      check($sformatf("to_wait_stalls_%0d", i), stalls(), 32'b1111);
      tick();
    end
    #1 check("to_err_set",     32'(hz.MemErr), 32'd1);
    check("to_err_stalls",  stalls(),  32'b1111);
    check("to_err_flushes", flushes(), 32'b001);
    hz.MemReadyM = 1'b1;
    hz.PCSrcE    = 1'b1;
    tick();
    tick();
    #1 check("to_err_sticky", 32'(hz.MemErr), 32'd1);
    check("to_err_hold", stalls(), 32'b1111);
    #1 rst = 1'b1;
    #1 check("to_rst_err",    32'(hz.MemErr), 32'd0);
    check("to_rst_stalls", stalls(), 32'b0000);
    clear_inputs();
    rst = 1'b0;
    #1 check("to_run_stalls", stalls(), 32'b0000);
    tick();
    check("to_run_after_edge", stalls(), 32'b0000);
    check("to_run_err", 32'(hz.MemErr), 32'd0);

    // Counter saturation and clear
    clear_counters();
    set_load_use();
    repeat (20) tick();
    check("sat_stallcnt", 32'(hz.StallCount), 32'd15);
    check("sat_flushcnt", 32'(hz.FlushCount), 32'd15);
    hz.CntClr = 1'b1;
    tick();
    hz.CntClr = 1'b0;
    clear_inputs();
    #1 check("clr_stallcnt", 32'(hz.StallCount), 32'd0);
    check("clr_flushcnt", 32'(hz.FlushCount), 32'd0);
    set_load_use();
    tick();
    clear_inputs();
    #1 check("cnt_restart", 32'(hz.StallCount), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and stall controller for the 20-bit-instruction, 22-bit-PC five-stage pipeline. It sits beside `decode_cycle_20` and the execute, memory and writeback stages. It generates:
- operand-forwarding selects for execute;
- load-use stalls;
- branch flushes;
- multi-cycle data-memory wait stalls, with a timeout error state.

It also keeps saturating stall and flush performance counters for debug.

## Interface
Parameters:
- MEM_TIMEOUT, 16, consecutive not-ready memory cycles before ERROR; legal range 2..255.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- RS1_D, RS2_D  in  5  source registers of the instruction in decode
- RS1_E, RS2_E, RD_E  in  5  source and destination registers in execute
- ResultSrcE  in  1  1 = instruction in execute is a load
- PCSrcE  in  1  1 = taken branch resolved in execute
- RD_M, RegWriteM  in  5/1  memory-stage destination and its write enable
- RD_W, RegWriteW  in  5/1  writeback-stage destination and its write enable
- MemReqM  in  1  memory stage is accessing data memory
- MemReadyM  in  1  data memory has completed the access this cycle
- CntClr  in  1  synchronous clear of both counters
- StallF, StallD, StallE, StallM  out  1  hold the fetch, decode, execute and memory pipeline registers
- FlushD, FlushE, FlushW  out  1  insert a bubble into the decode, execute and writeback registers
- ForwardAE, ForwardBE  out  2  select: 00 = register file, 01 = ResultW, 10 = ALU result from memory stage
- MemErr  out  1  sticky memory-timeout flag
- StallCount, FlushCount  out  CNT_W  performance counters

## Operation
State machine states: RUN, MEM_WAIT, ERROR. The outputs are combinational from the current state and the inputs; the state and the counters are registered.

Forwarding (always active, including in MEM_WAIT):
- ForwardAE = 10 if RegWriteM and RD_M != 0 and RD_M == RS1_E.
- Otherwise ForwardAE = 01 if RegWriteW and RD_W != 0 and RD_W == RS1_E.
- Otherwise ForwardAE = 00.
- ForwardBE uses the same rules with RS2_E.
- Register 0 is never forwarded.

Hazard conditions:
- memMiss = MemReqM and not MemReadyM.
- lwStall = ResultSrcE and RD_E != 0 and (RD_E == RS1_D or RD_E == RS2_D).

Priority, highest first: ERROR > memory wait > branch > load-use.
- **Memory wait.** Applies in MEM_WAIT with not MemReadyM, or in RUN with memMiss. Assert StallF, StallD, StallE, StallM and FlushW. Deassert FlushD and FlushE; a pending PCSrcE is held in the frozen execute stage and takes effect once the wait ends.
- **Branch.** PCSrcE asserts FlushD and FlushE, with no stall. lwStall is ignored in that cycle.
- **Load-use.** lwStall asserts StallF, StallD and FlushE.
- **ERROR.** All four stalls and FlushW asserted, MemErr = 1, held until rst.

State transitions (wcnt is an 8-bit internal counter):
- RUN with memMiss: go to MEM_WAIT, wcnt = 1. Otherwise stay in RUN.
- MEM_WAIT with MemReadyM: stalls drop in that same cycle; go to RUN.
- MEM_WAIT without MemReadyM: if wcnt + 1 == MEM_TIMEOUT, go to ERROR; otherwise wcnt += 1.

Counters:
- StallCount increments on every cycle with StallF = 1.
- FlushCount increments on every cycle with FlushE = 1.
- Both saturate at all-ones.
- CntClr zeroes both counters on the next edge and has priority over increments.

## Timing
- Reset values: state RUN, wcnt 0, MemErr 0, StallCount 0, FlushCount 0.
- While rst = 1, all Stall\*, Flush\* and Forward\* outputs are forced to 0.
- rst asserted in MEM_WAIT or ERROR returns the block to RUN immediately (asynchronous).
- Stall, flush and forward outputs have zero-cycle latency from their inputs.
- A load-use hazard costs exactly 1 stall cycle, because the load leaves execute on the next edge.
- A memory access ready in its first cycle causes no stall.
- A memory access ready on its Nth cycle causes N-1 stall cycles.
- ERROR is entered on the edge ending the MEM_TIMEOUT-th consecutive not-ready cycle. MemErr is visible from the following cycle.
- Counter values update one cycle after the qualifying output cycle.

## Test plan
- **Forwarding priority:** RS1_E = 3, RD_M = 3, RegWriteM = 1, RD_W = 3, RegWriteW = 1 -> ForwardAE = 10. Drop RegWriteM -> ForwardAE = 01. Set RS1_E = 0 with matching RD = 0 -> ForwardAE = 00.
- **Load-use:** ResultSrcE = 1, RD_E = 5, RS2_D = 5 for one cycle -> StallF = StallD = FlushE = 1 for exactly that cycle; StallCount = 1 and FlushCount = 1 on the next cycle.
- **Branch beats load-use:** PCSrcE = 1 together with lwStall -> FlushD = FlushE = 1, StallF = 0.
- **Memory wait:** MemReqM = 1, MemReadyM low for 3 cycles then high -> all stalls and FlushW high for 3 cycles; state returns to RUN; a PCSrcE held high throughout produces FlushD/FlushE only in the ready cycle.
- **Timeout:** MEM_TIMEOUT = 4, MemReqM = 1, MemReadyM = 0 forever -> MemErr = 1 from cycle 5, all stalls held; rst pulse -> MemErr = 0, state RUN.
- **Counters:** force StallCount near all-ones (CNT_W = 4, 20 stall cycles) -> saturates at 15. Then assert CntClr together with a stall -> reads 0.
